clk_meter: RTL

- Synthesizable measurement stage that sits directly downstream of the programmable clock/pulse generator.
- Samples the generated waveform (asynchronous to the system clock) and measures period and high time in system-clock cycles, averaging none, one result per waveform period.
- Flags a stuck or stopped waveform.
- Used in the block bench and on silicon to check frequency/duty settings against the generator's programmed ton/toff.

---
 rtl/clk_meter.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/clk_meter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : clk_meter
// Summary  : Measures the period and high time of an asynchronous waveform in
//            clk cycles, and flags a stuck waveform. Define CLK_METER_DUTY_PCT_EN
//            to add an iterative duty-cycle percentage divider.
// Revision : 1.0 - initial release
// ============================================================================
module clk_meter #(
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             sig_in,
    output logic [CNT_W-1:0] period_cyc,
    output logic [CNT_W-1:0] high_cyc,
    output logic             meas_valid,
    output logic             meas_ovf,
    output logic             stuck,
    output logic             stuck_level
`ifdef CLK_METER_DUTY_PCT_EN
    ,
    output logic [6:0]       duty_pct,
    output logic             duty_valid
`endif
);

    localparam logic [CNT_W-1:0] c_cnt_max    = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] c_one        = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_timeout_m1 = CNT_W'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ARM  = 2'd1,
        S_MEAS = 2'd2
    } state_t;

    state_t                 r_state, w_state_nxt;
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_hist;
    logic [CNT_W-1:0]       r_per_cnt, r_hi_cnt, r_hi_lat, r_idle_cnt;
    logic                   r_hi_done, r_sat;
    logic [CNT_W-1:0]       r_period, r_high;
    logic                   r_meas_valid, r_meas_ovf, r_stuck, r_stuck_level;
    logic                   w_sync_out, w_rise, w_fall, w_edge, w_timeout;

    assign w_sync_out = r_sync[SYNC_STAGES-1];
    assign w_rise     = w_sync_out & ~r_hist;
    assign w_fall     = ~w_sync_out & r_hist;
    assign w_edge     = w_rise | w_fall;
    // An edge in the same cycle restarts the idle count, so a rise beats the timeout.
    assign w_timeout  = en && (r_state != S_IDLE) && !w_edge && (r_idle_cnt == c_timeout_m1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= '0;
            r_hist <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], sig_in};
            r_hist <= w_sync_out;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (!en) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  w_state_nxt = S_ARM;
                S_ARM:   if (w_rise) w_state_nxt = S_MEAS;
                S_MEAS:  if (w_timeout) w_state_nxt = S_ARM;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_per_cnt     <= '0;
            r_hi_cnt      <= '0;
            r_hi_lat      <= '0;
            r_idle_cnt    <= '0;
            r_hi_done     <= 1'b0;
            r_sat         <= 1'b0;
            r_period      <= '0;
            r_high        <= '0;
            r_meas_valid  <= 1'b0;
            r_meas_ovf    <= 1'b0;
            r_stuck       <= 1'b0;
            r_stuck_level <= 1'b0;
        end else begin
            r_meas_valid <= 1'b0;
            if (!en || r_state == S_IDLE) begin
                r_per_cnt  <= '0;
                r_hi_cnt   <= '0;
                r_idle_cnt <= '0;
                r_hi_done  <= 1'b0;
                r_sat      <= 1'b0;
            end else begin
                if (w_edge) begin
                    r_idle_cnt <= '0;
                    r_stuck    <= 1'b0;
                end else if (w_timeout) begin
                    r_idle_cnt    <= '0;
                    r_stuck       <= 1'b1;
                    r_stuck_level <= w_sync_out;
                end else begin
                    r_idle_cnt <= r_idle_cnt + c_one;
                end

                if (w_rise) begin
                    if (r_state == S_MEAS) begin
                        r_period     <= r_per_cnt;
                        r_high       <= r_hi_lat;
                        r_meas_ovf   <= r_sat;
                        r_meas_valid <= 1'b1;
                    end
                    r_per_cnt <= c_one;
                    r_hi_cnt  <= c_one;
                    r_hi_done <= 1'b0;
                    r_sat     <= 1'b0;
                end else if (r_state == S_MEAS) begin
                    if (r_per_cnt == c_cnt_max) r_sat <= 1'b1;
                    else                        r_per_cnt <= r_per_cnt + c_one;
                    if (w_sync_out && !r_hi_done) begin
                        if (r_hi_cnt == c_cnt_max) r_sat <= 1'b1;
                        else                       r_hi_cnt <= r_hi_cnt + c_one;
                    end
                    if (w_fall) begin
                        r_hi_lat  <= r_hi_cnt;
                        r_hi_done <= 1'b1;
                    end
                end
            end
        end
    end

    assign period_cyc  = r_period;
    assign high_cyc    = r_high;
    assign meas_valid  = r_meas_valid;
    assign meas_ovf    = r_meas_ovf;
    assign stuck       = r_stuck;
    assign stuck_level = r_stuck_level;

`ifdef CLK_METER_DUTY_PCT_EN
    localparam int               c_dw      = CNT_W + 7;
    localparam int               c_cw      = $clog2(c_dw) + 1;
    localparam logic [c_dw-1:0]  c_hundred = c_dw'(100);

    logic [CNT_W:0]   r_rem, w_rem_src, w_rem_nxt;
    logic [c_dw-1:0]  r_dq, w_dq_src, w_dq_nxt;
    logic [CNT_W+1:0] w_trial, w_diff;
    logic [c_cw-1:0]  r_div_cnt;
    logic [6:0]       r_duty_pct;
    logic             r_duty_valid;

    // Restoring divider step; a fresh meas_valid feeds the first step directly
    // so the result lands exactly c_dw cycles after it.
    always_comb begin
        w_rem_src = r_rem;
        w_dq_src  = r_dq;
        if (r_meas_valid) begin
            w_rem_src = '0;
            w_dq_src  = c_dw'(r_high) * c_hundred;
        end
        w_trial = {w_rem_src, w_dq_src[c_dw-1]};
        w_diff  = w_trial - {2'b00, r_period};
        if (w_trial >= {2'b00, r_period}) begin
            w_rem_nxt = w_diff[CNT_W:0];
            w_dq_nxt  = {w_dq_src[c_dw-2:0], 1'b1};
        end else begin
            w_rem_nxt = w_trial[CNT_W:0];
            w_dq_nxt  = {w_dq_src[c_dw-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rem        <= '0;
            r_dq         <= '0;
            r_div_cnt    <= '0;
            r_duty_pct   <= '0;
            r_duty_valid <= 1'b0;
        end else begin
            r_duty_valid <= 1'b0;
            if (r_meas_valid) begin
                r_rem     <= w_rem_nxt;
                r_dq      <= w_dq_nxt;
                r_div_cnt <= c_cw'(c_dw - 1);
            end else if (r_div_cnt != '0) begin
                r_rem     <= w_rem_nxt;
                r_dq      <= w_dq_nxt;
                r_div_cnt <= r_div_cnt - c_cw'(1);
                if (r_div_cnt == c_cw'(1)) begin
                    r_duty_valid <= 1'b1;
                    r_duty_pct   <= (w_dq_nxt > c_hundred) ? 7'd100 : w_dq_nxt[6:0];
                end
            end
        end
    end

    assign duty_pct   = r_duty_pct;
    assign duty_valid = r_duty_valid;
`endif

endmodule
`default_nettype wire
